// File: rtl/mmul_parallel_kernel.sv
// mmul_parallel_kernel: two-stage multiply / scaled dot-product kernel with stream handshakes
module mmul_parallel_kernel #(
  parameter int CNT_LEN    = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ctrl_clear_i,
  input  logic                        ctrl_enable_i,
  input  logic                        ctrl_simple_mul_i,
  input  logic                        ctrl_start_i,
  input  logic [4:0]                  ctrl_shift_i,
  input  logic [$clog2(CNT_LEN):0]    ctrl_len_i,
  input  logic [DATA_WIDTH-1:0]       in1_data_i,
  input  logic                        in1_valid_i,
  output logic                        in1_ready_o,
  input  logic [DATA_WIDTH-1:0]       in2_data_i,
  input  logic                        in2_valid_i,
  output logic                        in2_ready_o,
  output logic [DATA_WIDTH-1:0]       out_r_data_o,
  output logic                        out_r_valid_o,
  input  logic                        out_r_ready_i,
  output logic [$clog2(CNT_LEN):0]    flags_cnt_o,
  output logic                        flags_done_o,
  output logic                        flags_idle_o,
  output logic                        flags_ready_o
);
  localparam int LW = $clog2(CNT_LEN) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t                  state_q, state_d;
  logic [LW-1:0]           cnt_q, cnt_d, len_q, len_d;
  logic [4:0]              shift_q, shift_d;
  logic                    simple_q, simple_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d, s1_q, s1_d, out_q, out_d;
  logic                    v1_q, v1_d, last1_q, last1_d, ov_q, ov_d;
  logic signed [2*DATA_WIDTH-1:0] prod, prod_sh;
  logic adv, consume, last_in, move, fire, start_ok;
  always_comb begin
    adv      = !ov_q || out_r_ready_i;
    in1_ready_o = (state_q == RUN) && ctrl_enable_i && adv;
    in2_ready_o = in1_ready_o;
    consume  = in1_ready_o && in1_valid_i && in2_valid_i;
    last_in  = consume && (cnt_q + LW'(1) == len_q);
    move     = v1_q && adv;
    // the output register is loaded per pair in simple mode, once per job in dot mode
    fire     = move && (simple_q || last1_q);
    start_ok = (state_q == IDLE) && ctrl_start_i;
    prod     = $signed(in1_data_i) * $signed(in2_data_i);
    prod_sh  = prod >>> shift_q;
    state_d  = (state_q == IDLE)  ? (ctrl_start_i ? ((ctrl_len_i == '0) ? DONE : RUN) : IDLE) :
               (state_q == RUN)   ? (last_in ? FLUSH : RUN) :
               (state_q == FLUSH) ? ((!v1_q && ov_q && out_r_ready_i) ? DONE : FLUSH) : IDLE;
    len_d    = start_ok ? ctrl_len_i : len_q;
    shift_d  = start_ok ? ctrl_shift_i : shift_q;
    simple_d = start_ok ? ctrl_simple_mul_i : simple_q;
    cnt_d    = start_ok ? '0 : consume ? cnt_q + LW'(1) : cnt_q;
    acc_d    = start_ok ? '0 : (move && !simple_q) ? acc_q + s1_q : acc_q;
    v1_d     = adv ? consume : v1_q;
    s1_d     = (adv && consume) ? prod_sh[DATA_WIDTH-1:0] : s1_q;
    last1_d  = (adv && consume) ? last_in : last1_q;
    ov_d     = fire ? 1'b1 : (ov_q && out_r_ready_i) ? 1'b0 : ov_q;
    out_d    = fire ? (simple_q ? s1_q : acc_q + s1_q) : out_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || ctrl_clear_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      shift_q  <= '0;
      simple_q <= 1'b0;
      acc_q    <= '0;
      s1_q     <= '0;
      v1_q     <= 1'b0;
      last1_q  <= 1'b0;
      ov_q     <= 1'b0;
      out_q    <= '0;
    end else if (ctrl_enable_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      shift_q  <= shift_d;
      simple_q <= simple_d;
      acc_q    <= acc_d;
      s1_q     <= s1_d;
      v1_q     <= v1_d;
      last1_q  <= last1_d;
      ov_q     <= ov_d;
      out_q    <= out_d;
    end
  end
  assign out_r_data_o  = out_q;
  assign out_r_valid_o = ov_q;
  assign flags_cnt_o   = cnt_q;
  assign flags_done_o  = (state_q == DONE);
  assign flags_idle_o  = (state_q == IDLE);
  assign flags_ready_o = (state_q == IDLE) && !ctrl_clear_i;
endmodule

// File: tb/tb_mmul_parallel_kernel.sv
// tb_mmul_parallel_kernel: scoreboard bench for the multiply / dot-product kernel
module tb_mmul_parallel_kernel;
  localparam int LW = 11;
  logic clk_i = 1'b0;
  logic rst_i, ctrl_clear_i, ctrl_enable_i, ctrl_simple_mul_i, ctrl_start_i;
  logic [4:0] ctrl_shift_i;
  logic [LW-1:0] ctrl_len_i, flags_cnt_o;
  logic [31:0] in1_data_i, in2_data_i, out_r_data_o;
  logic in1_valid_i, in1_ready_o, in2_valid_i, in2_ready_o, out_r_valid_o, out_r_ready_i;
  logic flags_done_o, flags_idle_o, flags_ready_o;
  int n_chk = 0, n_fail = 0;
  int a_v[16], b_v[16];
  logic [31:0] exp_q[$];
  always #5 clk_i = ~clk_i;
  mmul_parallel_kernel #(.CNT_LEN(1024), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
    .ctrl_simple_mul_i(ctrl_simple_mul_i), .ctrl_start_i(ctrl_start_i), .ctrl_shift_i(ctrl_shift_i),
    .ctrl_len_i(ctrl_len_i), .in1_data_i(in1_data_i), .in1_valid_i(in1_valid_i), .in1_ready_o(in1_ready_o),
    .in2_data_i(in2_data_i), .in2_valid_i(in2_valid_i), .in2_ready_o(in2_ready_o),
    .out_r_data_o(out_r_data_o), .out_r_valid_o(out_r_valid_o), .out_r_ready_i(out_r_ready_i),
    .flags_cnt_o(flags_cnt_o), .flags_done_o(flags_done_o), .flags_idle_o(flags_idle_o),
    .flags_ready_o(flags_ready_o)
  );
  function automatic logic [31:0] scaled(int a, int b, int sh);
    logic signed [63:0] p;
    p = longint'(a) * longint'(b);
    p = p >>> sh;
    return p[31:0];
  endfunction
  task automatic start_job(input bit simple, input int len, input int sh);
    ctrl_simple_mul_i = simple;
    ctrl_shift_i = sh[4:0];
    ctrl_len_i = len[LW-1:0];
    ctrl_start_i = 1'b1;
    @(negedge clk_i);
    ctrl_start_i = 1'b0;
  endtask
  task automatic run_job(input bit simple, input int len, input int sh, input bit bp);
    int idx = 0, first_c = -1, first_v = -1, last_hs = -1, done_it = -1, nout = 0, n_exp;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0, sum = '0, e;
    logic [LW-1:0] cnt_at_done = '0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      if (simple) exp_q.push_back(scaled(a_v[i], b_v[i], sh));
      else sum = sum + scaled(a_v[i], b_v[i], sh);
    end
    if (!simple) exp_q.push_back(sum);
    n_exp = exp_q.size();
    start_job(simple, len, sh);
    for (int it = 0; it < 600 && done_it < 0; it++) begin
      in1_valid_i = (idx < len) && (!bp || $urandom_range(0, 1) == 1);
      in2_valid_i = (idx < len) && (!bp || $urandom_range(0, 1) == 1);
      in1_data_i = a_v[idx < len ? idx : 0];
      in2_data_i = b_v[idx < len ? idx : 0];
      out_r_ready_i = !bp || $urandom_range(0, 1) == 1;
      #1;
      if (prev_stall) begin
        n_chk++;
        if (out_r_valid_o !== 1'b1 || out_r_data_o !== prev_data) begin
          n_fail++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", out_r_valid_o, out_r_data_o, prev_data);
        end
      end
      prev_stall = out_r_valid_o && !out_r_ready_i;
      prev_data = out_r_data_o;
      if (in1_ready_o && in1_valid_i && in2_valid_i) begin
        if (first_c < 0) first_c = it;
        idx++;
      end
      if (out_r_valid_o && out_r_ready_i) begin
        nout++;
        last_hs = it;
        if (first_v < 0) first_v = it;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_output: got %h required none", out_r_data_o);
        end else begin
          e = exp_q.pop_front();
          if (out_r_data_o !== e) begin
            n_fail++;
            $display("FAIL out_data: got %h required %h", out_r_data_o, e);
          end
        end
      end
      if (flags_done_o) begin
        done_it = it;
        cnt_at_done = flags_cnt_o;
      end
      @(negedge clk_i);
    end
    in1_valid_i = 0; in2_valid_i = 0; out_r_ready_i = 1;
    #1;
    n_chk++;
    if (done_it < 0) begin n_fail++; $display("FAIL done_timeout: no done pulse within budget"); end
    n_chk++;
    if (nout != n_exp) begin n_fail++; $display("FAIL out_count: got %0d required %0d", nout, n_exp); end
    n_chk++;
    if (done_it != last_hs + 1) begin n_fail++; $display("FAIL done_timing: done at %0d required %0d", done_it, last_hs + 1); end
    n_chk++;
    if (cnt_at_done !== len[LW-1:0]) begin n_fail++; $display("FAIL cnt: got %0d required %0d", cnt_at_done, len); end
    n_chk++;
    if (flags_done_o !== 1'b0 || flags_idle_o !== 1'b1) begin
      n_fail++; $display("FAIL post_done: done=%b idle=%b required done=0 idle=1", flags_done_o, flags_idle_o);
    end
    if (simple && !bp) begin
      n_chk++;
      if (first_v != first_c + 2) begin n_fail++; $display("FAIL latency: got %0d required 2", first_v - first_c); end
    end
  endtask
  task automatic test_reset;
    rst_i = 1; ctrl_clear_i = 0; ctrl_enable_i = 1; ctrl_simple_mul_i = 0; ctrl_start_i = 0;
    ctrl_shift_i = 0; ctrl_len_i = 0; in1_data_i = 0; in2_data_i = 0;
    in1_valid_i = 0; in2_valid_i = 0; out_r_ready_i = 1;
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    #1;
    n_chk++;
    if ({flags_idle_o, flags_ready_o, flags_done_o, out_r_valid_o, in1_ready_o, in2_ready_o} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 110000",
               {flags_idle_o, flags_ready_o, flags_done_o, out_r_valid_o, in1_ready_o, in2_ready_o});
    end
    n_chk++;
    if (out_r_data_o !== 32'd0 || flags_cnt_o !== '0) begin
      n_fail++; $display("FAIL reset_data: data=%h cnt=%0d required 0 0", out_r_data_o, flags_cnt_o);
    end
    ctrl_enable_i = 0; ctrl_len_i = 4; ctrl_start_i = 1;
    @(negedge clk_i);
    ctrl_start_i = 0; ctrl_enable_i = 1;
    #1;
    n_chk++;
    if (flags_idle_o !== 1'b1) begin n_fail++; $display("FAIL enable_stall: idle=%b required 1", flags_idle_o); end
    @(negedge clk_i);
  endtask
  task automatic test_dot;
    for (int i = 0; i < 4; i++) begin a_v[i] = i + 1; b_v[i] = i + 5; end
    run_job(0, 4, 0, 0);
  endtask
  task automatic test_simple;
    a_v[0] = 16; a_v[1] = -16; a_v[2] = 7;
    b_v[0] = 1; b_v[1] = 1; b_v[2] = 1;
    run_job(1, 3, 2, 0);
  endtask
  task automatic test_backpressure;
    for (int i = 0; i < 8; i++) begin a_v[i] = $urandom_range(0, 2000) - 1000; b_v[i] = $urandom(); end
    run_job(0, 8, 3, 1);
    for (int i = 0; i < 8; i++) begin a_v[i] = $urandom(); b_v[i] = $urandom_range(0, 60000) - 30000; end
    run_job(1, 8, 7, 1);
  endtask
  task automatic test_wrap;
    a_v[0] = 32'h7FFFFFFF; a_v[1] = 32'h7FFFFFFF; b_v[0] = 1; b_v[1] = 1;
    run_job(0, 2, 0, 0);
  endtask
  task automatic test_len0;
    start_job(0, 0, 0);
    #1;
    n_chk++;
    if (flags_done_o !== 1'b1 || out_r_valid_o !== 1'b0 || flags_idle_o !== 1'b0) begin
      n_fail++; $display("FAIL len0_done: done=%b valid=%b idle=%b required 1 0 0", flags_done_o, out_r_valid_o, flags_idle_o);
    end
    @(negedge clk_i);
    #1;
    n_chk++;
    if (flags_done_o !== 1'b0 || out_r_valid_o !== 1'b0 || flags_idle_o !== 1'b1) begin
      n_fail++; $display("FAIL len0_idle: done=%b valid=%b idle=%b required 0 0 1", flags_done_o, out_r_valid_o, flags_idle_o);
    end
  endtask
  task automatic test_abort(input bit use_rst);
    start_job(use_rst, 5, 0);
    in1_valid_i = 1; in2_valid_i = 1; in1_data_i = 2; in2_data_i = 3; out_r_ready_i = 1;
    repeat (2) @(negedge clk_i);
    in1_valid_i = 0; in2_valid_i = 0;
    #1;
    n_chk++;
    if (flags_cnt_o !== 11'd2) begin n_fail++; $display("FAIL abort_cnt: got %0d required 2", flags_cnt_o); end
    if (use_rst) rst_i = 1; else ctrl_clear_i = 1;
    ctrl_start_i = 1; ctrl_len_i = 3;
    #1;
    if (!use_rst) begin
      n_chk++;
      if (flags_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b required 0", flags_ready_o); end
    end
    @(negedge clk_i);
    rst_i = 0; ctrl_clear_i = 0; ctrl_start_i = 0;
    #1;
    n_chk++;
    if ({flags_idle_o, flags_ready_o, out_r_valid_o} !== 3'b110 || flags_cnt_o !== '0) begin
      n_fail++; $display("FAIL abort_state: idle/ready/valid=%b cnt=%0d required 110 0",
                         {flags_idle_o, flags_ready_o, out_r_valid_o}, flags_cnt_o);
    end
    @(negedge clk_i);
    n_chk++;
    if (flags_idle_o !== 1'b1) begin n_fail++; $display("FAIL abort_nostart: idle=%b required 1", flags_idle_o); end
    a_v[0] = 3; b_v[0] = 3;
    run_job(0, 1, 0, 0);
  endtask
  initial begin
    test_reset();
    test_dot();
    test_simple();
    test_backpressure();
    test_wrap();
    test_len0();
    test_abort(0);
    test_abort(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
